// File: rtl/crc16_pkg.sv
// crc16_pkg: USB CRC16 constants, checker state type and the single-bit LFSR step.
//   CRC16_INIT      LFSR seed loaded at the start of every packet
//   CRC16_RESIDUAL  remainder left after a good payload plus its complemented CRC
//   CRC16_POLY_TAPS XOR taps at bit positions {0, 2, 15} (x^16+x^15+x^2+1)
package crc16_pkg;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;
    localparam logic [15:0] CRC16_POLY_TAPS = 16'h8005;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} crc16_chk_state_e;
    // Shift left and fold the feedback bit (msb ^ serial input) into the taps.
    function automatic logic [15:0] crc16_step(input logic [15:0] r, input logic b);
        return {r[14:0], 1'b0} ^ ((r[15] ^ b) ? CRC16_POLY_TAPS : 16'h0000);
    endfunction
endpackage

// File: rtl/crc16_lfsr.sv
// crc16_lfsr: 16-bit USB CRC16 shift register, shared by generator and checker.
//   clk, rst_n  clock, asynchronous active-low reset (reset value CRC16_INIT)
//   load        reload CRC16_INIT (wins over shift)
//   shift       consume din this cycle
//   din         serial input bit
//   rem         live remainder
module crc16_lfsr
    import crc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] rem
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)     rem <= CRC16_INIT;
        else if (load)  rem <= CRC16_INIT;
        else if (shift) rem <= crc16_step(rem, din);
endmodule

// File: rtl/crc16_check.sv
// crc16_check: receive-side USB CRC16 checker with done/ack result handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   crc_start   arm for a new packet (also restarts / implicitly acks)
//   crc_abort   drop the current packet; highest priority
//   s_in        serial bit, consumed when bit_valid is high in ACCUM
//   bit_valid   s_in qualifier
//   crc_ack     result taken; return to IDLE
//   crc_busy    accumulating
//   crc_done    result valid, held until ack/start/abort
//   crc_ok      remainder matched the residual (valid with crc_done)
//   crc_err     crc_done & ~crc_ok
//   crc_rem     live remainder, only when CRC16_CHECK_DEBUG_EN is defined
module crc16_check
    import crc16_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_start,
    input  logic        crc_abort,
    input  logic        s_in,
    input  logic        bit_valid,
    input  logic        crc_ack,
    output logic        crc_busy,
    output logic        crc_done,
    output logic        crc_ok,
    output logic        crc_err
`ifdef CRC16_CHECK_DEBUG_EN
    ,
    output logic [15:0] crc_rem
`endif
);
    crc16_chk_state_e state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      rem;
    logic             last;

    assign last     = cnt == CNT_W'(DATA_BITS + 15);
    assign crc_busy = state == ACCUM;
    assign crc_err  = crc_done & ~crc_ok;
`ifdef CRC16_CHECK_DEBUG_EN
    assign crc_rem  = rem;
`endif

    crc16_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (crc_start & ~crc_abort),
        .shift (crc_busy & bit_valid & ~crc_start & ~crc_abort),
        .din   (s_in),
        .rem   (rem)
    );

    // The verdict is taken from the remainder the last bit is about to produce,
    // so crc_ok is registered on the same edge that accepts that bit.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
        end else if (crc_abort) begin
            state    <= IDLE;
            cnt      <= '0;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
        end else if (crc_start) begin
            state    <= ACCUM;
            cnt      <= '0;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
        end else begin
            case (state)
                ACCUM: if (bit_valid) begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        crc_done <= 1'b1;
                        crc_ok   <= crc16_step(rem, s_in) == CRC16_RESIDUAL;
                    end
                end
                DONE: if (crc_ack) begin
                    state    <= IDLE;
                    crc_done <= 1'b0;
                    crc_ok   <= 1'b0;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_crc16_check.sv
// tb_crc16_check: table-driven packet vectors plus directed abort/restart/reset sequences.
module tb_crc16_check;
    logic clk = 1'b0;
    logic rst_n, crc_start, crc_abort, s_in, bit_valid, crc_ack;
    logic crc_busy, crc_done, crc_ok, crc_err;
`ifdef CRC16_CHECK_DEBUG_EN
    logic [15:0] crc_rem;
`endif
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    crc16_check #(.DATA_BITS(64), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .crc_start (crc_start),
        .crc_abort (crc_abort),
        .s_in      (s_in),
        .bit_valid (bit_valid),
        .crc_ack   (crc_ack),
        .crc_busy  (crc_busy),
        .crc_done  (crc_done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err)
`ifdef CRC16_CHECK_DEBUG_EN
        ,
        .crc_rem   (crc_rem)
`endif
    );

    typedef struct {
        logic [63:0] payload;
        int          flip_d;
        int          flip_c;
        bit          gap;
        bit          exp_ok;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden transmit CRC: bitwise equations of x^16+x^15+x^2+1, seed FFFF,
    // payload MSB first, result complemented.
    function automatic logic [15:0] gen_crc(input logic [63:0] p);
        logic [15:0] r = 16'hFFFF;
        logic fb;
        for (int i = 63; i >= 0; i--) begin
            fb = r[15] ^ p[i];
            r  = {r[14] ^ fb, r[13:2], r[1] ^ fb, r[0], fb};
        end
        return ~r;
    endfunction

    function automatic logic [79:0] mk_stream(input logic [63:0] p, input int fd, input int fc);
        logic [79:0] s = {p, gen_crc(p)};
        if (fd >= 0) s[16+fd] = ~s[16+fd];
        if (fc >= 0) s[fc] = ~s[fc];
        return s;
    endfunction

    task automatic pulse_start();
        crc_start = 1'b1;
        @(negedge clk);
        crc_start = 1'b0;
    endtask

    // Sends s[hi] down to s[lo], optionally with random idle cycles carrying garbage.
    task automatic drive_bits(input logic [79:0] s, input int hi, input int lo, input bit gap);
        for (int i = hi; i >= lo; i--) begin
            while (gap && $urandom_range(1, 0) == 1) begin
                bit_valid = 1'b0;
                s_in = $urandom_range(1, 0) == 1;
                @(negedge clk);
            end
            bit_valid = 1'b1;
            s_in = s[i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
        s_in = 1'b0;
    endtask

    task automatic run_packet(input string name, input vec_t v);
        logic [79:0] s = mk_stream(v.payload, v.flip_d, v.flip_c);
        pulse_start();
        chk({name, " busy"}, crc_busy, 1);
        drive_bits(s, 79, 1, v.gap);
        chk({name, " not early"}, crc_done, 0);
        drive_bits(s, 0, 0, 1'b0);
        chk({name, " done"}, crc_done, 1);
        chk({name, " ok"}, crc_ok, v.exp_ok);
        chk({name, " err"}, crc_err, !v.exp_ok);
        chk({name, " busy off"}, crc_busy, 0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{64'h0123_4567_89AB_CDEF, -1, -1, 1'b0, 1'b1};
        tbl[1] = '{64'h0123_4567_89AB_CDEF, 10, -1, 1'b0, 1'b0};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, -1,  3, 1'b0, 1'b0};
        tbl[3] = '{64'h0123_4567_89AB_CDEF, -1, -1, 1'b1, 1'b1};
        tbl[4] = '{64'hFFFF_0000_A5A5_5A5A, -1, -1, 1'b1, 1'b1};

        rst_n = 1'b0; crc_start = 1'b0; crc_abort = 1'b0;
        s_in = 1'b0; bit_valid = 1'b0; crc_ack = 1'b0;
        #2;
        chk("reset busy", crc_busy, 0);
        chk("reset done", crc_done, 0);
        chk("reset ok", crc_ok, 0);
        chk("reset err", crc_err, 0);
`ifdef CRC16_CHECK_DEBUG_EN
        chk("reset rem", crc_rem, 16'hFFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: each packet, then 20 ignored bits in DONE, then ack.
        for (int k = 0; k < 5; k++) begin
            run_packet($sformatf("vec%0d", k), tbl[k]);
            for (int j = 0; j < 20; j++) begin
                bit_valid = 1'b1;
                s_in = j[0];
                @(negedge clk);
            end
            bit_valid = 1'b0;
            chk($sformatf("vec%0d hold done", k), crc_done, 1);
            chk($sformatf("vec%0d hold ok", k), crc_ok, tbl[k].exp_ok);
            crc_ack = 1'b1;
            @(negedge clk);
            crc_ack = 1'b0;
            chk($sformatf("vec%0d ack done", k), crc_done, 0);
            chk($sformatf("vec%0d ack err", k), crc_err, 0);
        end

        // Abort after 30 bits, then a good packet.
        pulse_start();
        drive_bits(mk_stream(tbl[0].payload, -1, -1), 79, 50, 1'b0);
        crc_abort = 1'b1;
        @(negedge clk);
        crc_abort = 1'b0;
        chk("abort busy", crc_busy, 0);
        drive_bits(mk_stream(tbl[0].payload, -1, -1), 49, 0, 1'b0);
        chk("abort no done", crc_done, 0);
        run_packet("after abort", tbl[0]);

        // Start in DONE without ack, interrupted at bit 40 by another start.
        pulse_start();
        chk("start in done clears", crc_done, 0);
        drive_bits(mk_stream(tbl[4].payload, -1, -1), 79, 40, 1'b0);
        run_packet("restart", tbl[0]);

        // Abort and start together -> IDLE.
        pulse_start();
        drive_bits(mk_stream(tbl[0].payload, -1, -1), 79, 70, 1'b0);
        crc_abort = 1'b1;
        crc_start = 1'b1;
        @(negedge clk);
        crc_abort = 1'b0;
        crc_start = 1'b0;
        chk("abort+start busy", crc_busy, 0);
        drive_bits(mk_stream(tbl[0].payload, -1, -1), 69, 0, 1'b0);
        chk("abort+start no done", crc_done, 0);

        // Asynchronous reset mid-ACCUM.
        pulse_start();
        drive_bits(mk_stream(tbl[0].payload, -1, -1), 79, 60, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst accum busy", crc_busy, 0);
        chk("rst accum done", crc_done, 0);
`ifdef CRC16_CHECK_DEBUG_EN
        chk("rst accum rem", crc_rem, 16'hFFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in DONE.
        run_packet("pre-reset", tbl[1]);
        #2 rst_n = 1'b0;
        #1;
        chk("rst done done", crc_done, 0);
        chk("rst done ok", crc_ok, 0);
        chk("rst done err", crc_err, 0);
        chk("rst done busy", crc_busy, 0);
`ifdef CRC16_CHECK_DEBUG_EN
        chk("rst done rem", crc_rem, 16'hFFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_packet("post-reset", tbl[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
